// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network front end.
//
// Contents:
//   DATA_WIDTH  - width of one Q8.8 word fed to the network
//   FRAC_BITS   - number of fractional bits in that word
//   PIXEL_SHIFT - left shift that maps a raw 8-bit pixel onto Q8.8
//                 (255 -> 16'h1FE0, i.e. roughly 0.0 .. 32.0)
//   state_t     - frame loader FSM states
package nn_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int FRAC_BITS   = 8;
  localparam int PIXEL_SHIFT = 5;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/nn_input_loader.sv
// Frame loader: collects a row-major stream of raw pixels into one wide
// packed word vector for the network, fires a one-cycle NNvalid once the
// frame is complete, then holds the vector until the classifier reports
// completion on resultDone.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   pixIn      - raw pixel, index 0 first
//   pixValid   - pixIn valid this cycle
//   pixLast    - source's end-of-frame marker (qualified by pixValid)
//   pixReady   - loader accepts a pixel this cycle
//   resultDone - downstream classification complete
//   NNin       - packed frame, word k at [dataWidth*k +: dataWidth]
//   NNvalid    - one-cycle frame-ready pulse
//   frameErr   - one-cycle pulse when a short frame is discarded
//   frameCount - number of frames issued, wrapping
module nn_input_loader
  import nn_pkg::*;
#(
  parameter int numInputs  = 784,
  parameter int dataWidth  = DATA_WIDTH,
  parameter int pixelWidth = 8,
  parameter int pixelShift = PIXEL_SHIFT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [pixelWidth-1:0]           pixIn,
  input  logic                            pixValid,
  input  logic                            pixLast,
  output logic                            pixReady,
  input  logic                            resultDone,
  output logic [dataWidth*numInputs-1:0]  NNin,
  output logic                            NNvalid,
  output logic                            frameErr,
  output logic [15:0]                     frameCount
);

  localparam int CNT_W = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numInputs - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             xfer;
  logic             final_pix;
  logic             early_last;
  logic             frame_err;
  logic [15:0]      frame_cnt;

  function automatic logic [dataWidth-1:0] pix_to_word(input logic [pixelWidth-1:0] p);
    pix_to_word = dataWidth'(p) << pixelShift;
  endfunction

  always_comb begin
    pixReady   = (state == LOAD);
    NNvalid    = (state == FIRE);
    xfer       = pixValid && (state == LOAD);
    // The pixel count alone decides the end of a frame; pixLast only
    // matters when it arrives too early.
    final_pix  = xfer && (cnt == LAST_IDX);
    early_last = xfer && pixLast && !final_pix;
    state_next = state;
    cnt_next   = cnt;
    case (state)
      LOAD: begin
        if (final_pix) begin
          state_next = FIRE;
          cnt_next   = '0;
        end else if (early_last) begin
          cnt_next   = '0;
        end else if (xfer) begin
          cnt_next   = cnt + 1'b1;
        end
      end
      FIRE: state_next = WAIT;
      WAIT: begin
        if (resultDone) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = LOAD;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      frame_err <= 1'b0;
      frame_cnt <= 16'h0000;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      frame_err <= early_last;
      if (state == FIRE) frame_cnt <= frame_cnt + 16'h0001;
    end
  end

  // Word write: the counter selects the destination word directly, so
  // words of an abandoned frame stay stale until the next frame rewrites them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      NNin <= '0;
    end else if (xfer) begin
      NNin[int'(cnt)*dataWidth +: dataWidth] <= pix_to_word(pixIn);
    end
  end

  assign frameErr   = frame_err;
  assign frameCount = frame_cnt;

endmodule

// File: tb/tb_nn_input_loader.sv
// Self-checking bench for nn_input_loader with the default 784 x Q8.8 frame.
module tb_nn_input_loader;

  localparam int N = 784;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      pix_in;
  logic            pix_valid;
  logic            pix_last;
  logic            pix_ready;
  logic            result_done;
  logic [16*N-1:0] nn_in;
  logic            nn_valid;
  logic            frame_err;
  logic [15:0]     frame_count;

  nn_input_loader dut (
    .clk        (clk),
    .reset      (reset),
    .pixIn      (pix_in),
    .pixValid   (pix_valid),
    .pixLast    (pix_last),
    .pixReady   (pix_ready),
    .resultDone (result_done),
    .NNin       (nn_in),
    .NNvalid    (nn_valid),
    .frameErr   (frame_err),
    .frameCount (frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the frame as a list of accepted pixels
  logic [15:0] exp_w [N];
  int          m_idx       = 0;
  int          exp_frames  = 0;
  int          exp_err     = 0;

  // Pulse monitors and cycle counter
  int nv_cnt = 0;
  int fe_cnt = 0;
  int cyc    = 0;

  always @(negedge clk) begin
    if (nn_valid === 1'b1) nv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) exp_w[k] = 16'h0000;
    m_idx = 0;
  endtask

  task automatic model_accept(input logic [7:0] v, input bit last);
    exp_w[m_idx] = 16'(int'(v) * 32);
    if (m_idx == N - 1) begin
      m_idx = 0;
      exp_frames++;
    end else if (last) begin
      m_idx = 0;
      exp_err++;
    end else begin
      m_idx++;
    end
  endtask

  function automatic int count_mism();
    int n = 0;
    for (int k = 0; k < N; k++)
      if (nn_in[k*16 +: 16] !== exp_w[k]) n++;
    return n;
  endfunction

  // Offer one pixel until it is accepted; optionally idle random cycles first.
  task automatic push(input logic [7:0] v, input bit last, input bit throttle);
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      if (throttle && ($urandom_range(0, 1) == 0)) begin
        pix_valid = 1'b0;
        pix_in    = 8'($urandom);
        pix_last  = 1'($urandom);
        cycle();
      end else begin
        pix_valid = 1'b1;
        pix_in    = v;
        pix_last  = last;
        if (pix_ready === 1'b1) begin
          model_accept(v, last);
          done = 1'b1;
        end
        cycle();
      end
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL push_timeout: pixel never accepted, pixReady=%b", pix_ready);
    end
  endtask

  task automatic release_wait();
    result_done = 1'b1;
    cycle();
    result_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cycle();
    tests++; if (nn_in !== '0) begin fails++; $display("FAIL reset_nnin: got nonzero, want 0"); end
    tests++; if (nn_valid !== 1'b0) begin fails++; $display("FAIL reset_nnvalid: got %b want 0", nn_valid); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frameerr: got %b want 0", frame_err); end
    tests++; if (frame_count !== 16'h0000) begin fails++; $display("FAIL reset_framecount: got %h want 0000", frame_count); end
    reset = 1'b1;
    cycle();
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", pix_ready); end
  endtask

  task automatic test_full_frame();
    int c0;
    c0 = cyc;
    for (int k = 0; k < N; k++) push(8'(k % 256), k == N - 1, 1'b0);
    tests++; if (cyc - c0 != N) begin fails++; $display("FAIL full_throughput: got %0d cycles want %0d", cyc - c0, N); end
    tests++; if (nn_valid !== 1'b1) begin fails++; $display("FAIL full_nnvalid: got %b want 1", nn_valid); end
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL full_ready_fire: got %b want 0", pix_ready); end
    cycle();
    tests++; if (nn_valid !== 1'b0) begin fails++; $display("FAIL full_nnvalid_pulse: got %b want 0", nn_valid); end
    tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL full_framecount: got %0d want 1", frame_count); end
    tests++; if (nn_in[0 +: 16] !== 16'h0000) begin fails++; $display("FAIL full_word0: got %h want 0000", nn_in[0 +: 16]); end
    tests++; if (nn_in[255*16 +: 16] !== 16'h1FE0) begin fails++; $display("FAIL full_word255: got %h want 1fe0", nn_in[255*16 +: 16]); end
    tests++; if (count_mism() != 0) begin fails++; $display("FAIL full_words: %0d words differ, want 0", count_mism()); end
    tests++; if (nv_cnt != exp_frames) begin fails++; $display("FAIL full_pulses: got %0d want %0d", nv_cnt, exp_frames); end
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL full_ready_wait: got %b want 0", pix_ready); end
  endtask

  task automatic test_wait_hold();
    logic [16*N-1:0] snap;
    int bad = 0;
    snap      = nn_in;
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    repeat (50) begin
      if (pix_ready !== 1'b0) bad++;
      cycle();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wait_ready: ready high on %0d cycles, want 0", bad); end
    tests++; if (nn_in !== snap) begin fails++; $display("FAIL wait_hold: NNin changed, want unchanged"); end
    tests++; if (nv_cnt != exp_frames) begin fails++; $display("FAIL wait_pulses: got %0d want %0d", nv_cnt, exp_frames); end
    pix_valid = 1'b0;
    release_wait();
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL wait_release: got %b want 1", pix_ready); end
  endtask

  task automatic test_early_last();
    int n0;
    int bad = 0;
    n0 = nv_cnt;
    for (int k = 0; k <= 100; k++) push(8'($urandom), k == 100, 1'b0);
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL early_err: got %b want 1", frame_err); end
    cycle();
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL early_err_pulse: got %b want 0", frame_err); end
    tests++; if (fe_cnt != exp_err) begin fails++; $display("FAIL early_err_count: got %0d want %0d", fe_cnt, exp_err); end
    tests++; if (nv_cnt != n0) begin fails++; $display("FAIL early_no_valid: got %0d want %0d", nv_cnt, n0); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL early_ready: got %b want 1", pix_ready); end
    for (int k = 0; k < N; k++) push(8'hFF, k == N - 1, 1'b0);
    cycle();
    for (int k = 0; k < N; k++) if (nn_in[k*16 +: 16] !== 16'h1FE0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL early_words: %0d words not 1fe0, want 0", bad); end
    tests++; if (nv_cnt != n0 + 1) begin fails++; $display("FAIL early_one_valid: got %0d want %0d", nv_cnt - n0, 1); end
    release_wait();
  endtask

  task automatic test_throttled();
    int n0;
    n0 = nv_cnt;
    result_done = 1'b1;
    for (int k = 0; k < N - 1; k++) push(8'($urandom), 1'b0, 1'b1);
    tests++; if (nv_cnt != n0) begin fails++; $display("FAIL thr_early_valid: got %0d want %0d", nv_cnt, n0); end
    push(8'($urandom), 1'b0, 1'b1);
    tests++; if (nn_valid !== 1'b1) begin fails++; $display("FAIL thr_nnvalid: got %b want 1", nn_valid); end
    cycle();
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL thr_fire_ignores_done: got %b want 0", pix_ready); end
    tests++; if (count_mism() != 0) begin fails++; $display("FAIL thr_words: %0d words differ, want 0", count_mism()); end
    tests++; if (frame_count !== 16'd3) begin fails++; $display("FAIL thr_framecount: got %0d want 3", frame_count); end
    cycle();
    result_done = 1'b0;
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL thr_release: got %b want 1", pix_ready); end
    tests++; if (nv_cnt != n0 + 1) begin fails++; $display("FAIL thr_pulses: got %0d want %0d", nv_cnt - n0, 1); end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    int e0;
    n0 = nv_cnt;
    e0 = fe_cnt;
    for (int k = 0; k < 400; k++) push(8'($urandom), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_clear();
    tests++; if (nn_in !== '0) begin fails++; $display("FAIL rst_nnin: got nonzero, want 0"); end
    tests++; if (frame_count !== 16'h0000) begin fails++; $display("FAIL rst_framecount: got %h want 0000", frame_count); end
    cycle();
    reset = 1'b1;
    cycle();
    tests++; if (fe_cnt != e0 || nv_cnt != n0) begin fails++; $display("FAIL rst_no_pulse: err %0d valid %0d, want %0d %0d", fe_cnt, nv_cnt, e0, n0); end
    for (int k = 0; k < N - 1; k++) push(8'($urandom), 1'b0, 1'b0);
    tests++; if (nv_cnt != n0) begin fails++; $display("FAIL rst_early_valid: got %0d want %0d", nv_cnt, n0); end
    push(8'($urandom), 1'b1, 1'b0);
    tests++; if (nn_valid !== 1'b1) begin fails++; $display("FAIL rst_nnvalid: got %b want 1", nn_valid); end
    cycle();
    tests++; if (count_mism() != 0) begin fails++; $display("FAIL rst_words: %0d words differ, want 0", count_mism()); end
    tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL rst_framecount_after: got %0d want 1", frame_count); end
    release_wait();
  endtask

  task automatic test_count_wrap();
    force dut.frame_cnt = 16'hFFFF;
    #2;
    release dut.frame_cnt;
    tests++; if (frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h want ffff", frame_count); end
    for (int k = 0; k < N; k++) push(8'($urandom), k == N - 1, 1'b0);
    cycle();
    tests++; if (frame_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h want 0000", frame_count); end
    tests++; if (count_mism() != 0) begin fails++; $display("FAIL wrap_words: %0d words differ, want 0", count_mism()); end
    release_wait();
  endtask

  initial begin
    pix_in      = 8'h00;
    pix_valid   = 1'b0;
    pix_last    = 1'b0;
    result_done = 1'b0;
    model_clear();
    test_reset();
    test_full_frame();
    test_wait_hold();
    test_early_last();
    test_throttled();
    test_reset_mid_frame();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_input_loader.md
NN_INPUT_LOADER -- requirements
Module: nn_input_loader

Interface
REQ-001 Parameter numInputs, default 784, SHALL set the number of pixels per frame.
REQ-002 Parameter dataWidth, default 16, SHALL set the Q8.8 word width of each packed input word.
REQ-003 Parameter pixelWidth, default 8, SHALL set the raw pixel width.
REQ-004 Parameter pixelShift, default 5, SHALL set the left shift from raw pixel to data word.
REQ-005 Port clk, input, 1 bit: sole clock; all state SHALL change on its rising edge.
REQ-006 Port reset, input, 1 bit: SHALL be an asynchronous, active-low reset.
REQ-007 Port pixIn, input, pixelWidth bits: raw pixel, row-major, index 0 first.
REQ-008 Port pixValid, input, 1 bit: pixIn is valid this cycle.
REQ-009 Port pixLast, input, 1 bit: marks the final pixel of the frame; qualified by pixValid.
REQ-010 Port pixReady, output, 1 bit: the loader accepts a pixel this cycle.
REQ-011 Port resultDone, input, 1 bit: downstream classification complete; driven from the hardmax maxValid.
REQ-012 Port NNin, output, dataWidth*numInputs bits: packed frame feeding NeuralNetwork NNin.
REQ-013 Port NNvalid, output, 1 bit: one-cycle frame-ready pulse feeding NeuralNetwork NNvalid.
REQ-014 Port frameErr, output, 1 bit: one-cycle pulse when a frame is discarded.
REQ-015 Port frameCount, output, 16 bits: count of frames issued; wraps.

Function
REQ-016 A pixel transfer SHALL occur on a cycle where pixValid and pixReady are both 1.
REQ-017 Pixel k SHALL be stored at NNin[dataWidth*k +: dataWidth] as zero-extended pixIn << pixelShift; 255 SHALL map to 16'h1FE0 and 0 to 16'h0000.
REQ-018 FSM states SHALL be LOAD, FIRE and WAIT; the reset state SHALL be LOAD.
REQ-019 In LOAD, pixReady SHALL be 1 and the pixel counter (width $clog2(numInputs)) SHALL increment on each transfer.
REQ-020 The transfer at counter = numInputs-1 SHALL store the pixel and move the FSM to FIRE.
REQ-021 pixLast on that final transfer SHALL be ignored; a missing pixLast at the final pixel SHALL NOT be an error.
REQ-022 pixLast on a transfer with counter < numInputs-1 SHALL cause the following:
  - pulse frameErr for one cycle;
  - reset the counter to 0;
  - stay in LOAD;
  - suppress NNvalid.
  Already-written words SHALL be left stale, since they are overwritten by the next frame.
REQ-023 In FIRE, NNvalid SHALL be 1 for exactly one cycle, pixReady SHALL be 0, and frameCount SHALL increment (wrapping from 16'hFFFF to 0).
REQ-024 The FSM SHALL move from FIRE to WAIT unconditionally, so NNvalid rises 1 cycle after the final transfer.
REQ-025 In WAIT, pixReady SHALL be 0, NNin SHALL be held stable, and resultDone=1 SHALL move the FSM to LOAD with counter = 0.
REQ-026 resultDone SHALL be ignored in LOAD and FIRE.
REQ-027 NNin SHALL change only on a transfer in LOAD.
REQ-028 NNin SHALL NOT change in FIRE or WAIT.
REQ-029 A pixValid asserted while pixReady=0 SHALL NOT be consumed; the source holds its data.
REQ-030 Sustained throughput SHALL be 1 pixel/cycle in LOAD.

Reset
REQ-031 While reset=0, the following SHALL hold:
  - state = LOAD, counter = 0;
  - NNin all zero;
  - NNvalid = 0, frameErr = 0;
  - frameCount = 0;
  - pixReady = 1 after release.
REQ-032 Reset asserted mid-frame or in WAIT SHALL abandon the frame without producing NNvalid or frameErr.

Structure
REQ-033 The state enum and the pixel-to-Q8.8 conversion constant (pixelShift default) SHALL reside in shared package nn_pkg alongside the dataWidth/fraction constants.
REQ-034 The block SHALL be a single module with no sub-modules; the word-index decoder SHALL be written inline.

Verification
REQ-035 The bench SHALL cover a full frame:
  - stimulus: after reset, 784 back-to-back pixels with value (k mod 256) and pixLast on k=783;
  - response: NNvalid pulses 1 cycle after the final transfer, word 0 = 16'h0000, word 255 = 16'h1FE0, frameCount = 1, pixReady = 0.
REQ-036 The bench SHALL cover WAIT hold:
  - stimulus: in WAIT, drive pixValid=1 with pixIn=8'hAA for 50 cycles;
  - response: no transfer occurs and NNin is unchanged;
  - stimulus: then pulse resultDone;
  - response: pixReady=1 on the next cycle.
REQ-037 The bench SHALL cover an early pixLast:
  - stimulus: pixLast on pixel index 100;
  - response: frameErr pulses, no NNvalid;
  - stimulus: then 784 pixels of 8'hFF;
  - response: all words = 16'h1FE0 and exactly one NNvalid.
REQ-038 The bench SHALL cover throttled input:
  - stimulus: pixValid randomly low 50% of cycles over a full frame;
  - response: stored words match the transferred sequence and NNvalid fires after exactly 784 transfers.
REQ-039 The bench SHALL cover reset mid-frame:
  - stimulus: reset=0 after 400 pixels, then release;
  - response: NNin = 0, counter = 0, frameCount unchanged from its reset value 0, and the next 784 pixels yield one NNvalid.
REQ-040 The bench SHALL cover frameCount wrap:
  - stimulus: preload frameCount to 16'hFFFF (force), then complete one frame;
  - response: frameCount = 16'h0000.
